// File: rtl/res_drain.sv
// rtl/res_drain.sv - drains result banks 8..15 through a credit-limited return FIFO into 256-bit beats
module res_drain (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [12:0]  tran_time,
    output logic         busy,
    output logic         done,
    output logic         bce,
    output logic [2:0]   bsel,
    output logic [14:0]  braddr,
    input  logic [127:0] brdata,
    input  logic         brvalid,
    output logic [255:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t        state, state_nxt;
    logic [12:0]   tt_r;
    logic [12:0]   addr_cnt;
    logic [2:0]    bank_cnt;
    logic [2:0]    outstanding;
    logic [2:0]    fifo_cnt;
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [127:0]  fifo_mem [4];
    logic [127:0]  lo_word;
    logic          lo_full;
    logic [255:0]  dout_r;
    logic          dout_valid_r;
    logic [14:0]   beat_cnt;
    logic [14:0]   beats_total;

    logic accept_start;
    logic issue;
    logic last_read;
    logic push;
    logic pop;
    logic slot_free;
    logic accept;
    logic last_beat;

    assign accept_start = start && (state == IDLE);
    // Credits count both buffered and in-flight words so a return always has a free slot.
    assign issue        = (state == RUN) && (({1'b0, fifo_cnt} + {1'b0, outstanding}) < 4'd4);
    assign last_read    = issue && (bank_cnt == 3'd7) && (addr_cnt == tt_r - 13'd1);
    assign push         = brvalid && (outstanding != 3'd0);
    assign slot_free    = !dout_valid_r || dout_ready;
    assign pop          = (fifo_cnt != 3'd0) && (!lo_full || slot_free);
    assign accept       = dout_valid_r && dout_ready;
    assign beats_total  = {tt_r, 2'b00};
    assign last_beat    = accept && (beat_cnt == beats_total - 15'd1);

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign bce        = issue;
    assign bsel       = bank_cnt;
    assign braddr     = {2'b00, addr_cnt};
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (tran_time == 13'd0) ? DONE : RUN;
            RUN:   if (last_read) state_nxt = FLUSH;
            FLUSH: if (last_beat) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_r     <= '0;
            addr_cnt <= '0;
            bank_cnt <= '0;
            beat_cnt <= '0;
        end else if (accept_start) begin
            tt_r     <= tran_time;
            addr_cnt <= '0;
            bank_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            if (issue) begin
                bank_cnt <= bank_cnt + 3'd1;
                // The final address holds rather than wrapping back to 0.
                if (bank_cnt == 3'd7 && !last_read)
                    addr_cnt <= addr_cnt + 13'd1;
            end
            if (state == DONE) begin
                addr_cnt <= '0;
                bank_cnt <= '0;
            end
            if (accept)
                beat_cnt <= beat_cnt + 15'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            fifo_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding + {2'b00, issue} - {2'b00, push};
            fifo_cnt    <= fifo_cnt + {2'b00, push} - {2'b00, pop};
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= brdata;
    end

    // First popped word parks in lo_word; the second completes the beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_word      <= '0;
            lo_full      <= 1'b0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
        end else begin
            if (accept)
                dout_valid_r <= 1'b0;
            if (pop) begin
                if (lo_full) begin
                    dout_r       <= {fifo_mem[rd_ptr], lo_word};
                    dout_valid_r <= 1'b1;
                    lo_full      <= 1'b0;
                end else begin
                    lo_word <= fifo_mem[rd_ptr];
                    lo_full <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_res_drain.sv
// tb/tb_res_drain.sv - directed table-driven bench for res_drain with bank model and beat scoreboard
module tb_res_drain;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [12:0]  tran_time = '0;
    logic         busy, done, bce;
    logic [2:0]   bsel;
    logic [14:0]  braddr;
    logic [127:0] brdata = '0;
    logic         brvalid = 1'b0;
    logic [255:0] dout;
    logic         dout_valid;
    logic         dout_ready = 1'b1;

    res_drain dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tran_time(tran_time),
        .busy(busy), .done(done), .bce(bce), .bsel(bsel), .braddr(braddr),
        .brdata(brdata), .brvalid(brvalid), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] word_of(input int b, input int a);
        logic [7:0] byt;
        byt = 8'h80 | 8'(b);
        return {16{byt}} ^ {16'(a), 112'd0};
    endfunction

    function automatic logic [255:0] exp_beat(input int j);
        return {word_of(2 * (j % 4) + 1, j / 4), word_of(2 * (j % 4), j / 4)};
    endfunction

    typedef struct {
        int b;
        int a;
        int due;
    } req_t;

    req_t         pend[$];
    int           cyc = 0;
    int           lat = 1;
    int           reads_seen = 0;
    int           beats_seen = 0;
    int           dones_seen = 0;
    int           dv_seen = 0;
    int           first_acc = 0;
    int           last_acc = 0;
    bit           stale_inj = 1'b0;
    logic         prev_hold = 1'b0;
    logic [255:0] prev_dout = '0;

    // Bank model and output monitor, evaluated just after each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (prev_hold) begin
                chk("hold_valid", 256'(dout_valid), 256'(1));
                chk("hold_data", dout, prev_dout);
            end
            prev_hold = dout_valid && !dout_ready && rst_n;
            prev_dout = dout;
            if (dout_valid && dout_ready) begin
                chk("beat", dout, exp_beat(beats_seen));
                if (beats_seen == 0) first_acc = cyc;
                last_acc = cyc;
                beats_seen++;
            end
            if (done) dones_seen++;
            if (dout_valid) dv_seen++;
            brvalid = 1'b0;
            brdata  = '0;
            if (stale_inj) begin
                brvalid = 1'b1;
                brdata  = {8{16'hDEAD}};
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                brvalid = 1'b1;
                brdata  = word_of(pend[0].b, pend[0].a);
                void'(pend.pop_front());
            end
            if (bce) begin
                chk("rd_bank", 256'(bsel), 256'(reads_seen % 8));
                chk("rd_addr", 256'(braddr), 256'(reads_seen / 8));
                pend.push_back('{int'(bsel), int'(braddr), cyc + lat});
                reads_seen++;
            end
        end
    end

    task automatic clear_counts();
        reads_seen = 0;
        beats_seen = 0;
        dones_seen = 0;
        dv_seen    = 0;
        first_acc  = 0;
        last_acc   = 0;
    endtask

    task automatic pulse_start(input int tt);
        @(negedge clk);
        tran_time = 13'(tt);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (dones_seen == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (dones_seen == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done within %0d cycles", budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 256'(busy), 256'(0));
        chk({tag, "_done"}, 256'(done), 256'(0));
        chk({tag, "_bce"}, 256'(bce), 256'(0));
        chk({tag, "_bsel"}, 256'(bsel), 256'(0));
        chk({tag, "_braddr"}, 256'(braddr), 256'(0));
        chk({tag, "_dout"}, dout, 256'(0));
        chk({tag, "_dout_valid"}, 256'(dout_valid), 256'(0));
    endtask

    typedef struct {
        int tt;
        int lat;
        int stall;
        int stall_reads;
        int reads;
        int beats;
        int gap;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int n;
        vecs[0] = '{1, 1, 0,  0,  8,  4,  6};
        vecs[1] = '{2, 1, 0,  0, 16,  8, 14};
        vecs[2] = '{4, 1, 20, 7, 32, 16, -1};
        vecs[3] = '{3, 3, 0,  0, 24, 12, -1};

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            clear_counts();
            lat        = vecs[i].lat;
            dout_ready = (vecs[i].stall == 0);
            pulse_start(vecs[i].tt);
            if (vecs[i].stall > 0) begin
                repeat (vecs[i].stall) @(negedge clk);
                chk("stall_reads", 256'(reads_seen), 256'(vecs[i].stall_reads));
                dout_ready = 1'b1;
            end
            wait_done(3000);
            chk("reads", 256'(reads_seen), 256'(vecs[i].reads));
            chk("beats", 256'(beats_seen), 256'(vecs[i].beats));
            chk("dones", 256'(dones_seen), 256'(1));
            chk("busy_after", 256'(busy), 256'(0));
            if (vecs[i].gap >= 0)
                chk("beat_rate", 256'(last_acc - first_acc), 256'(vecs[i].gap));
        end

        clear_counts();
        lat = 1;
        pulse_start(0);
        #2;
        chk("zero_done", 256'(done), 256'(1));
        chk("zero_bce", 256'(bce), 256'(0));
        @(negedge clk);
        #2;
        chk("zero_done_low", 256'(done), 256'(0));
        chk("zero_busy", 256'(busy), 256'(0));
        repeat (3) @(negedge clk);
        chk("zero_reads", 256'(reads_seen), 256'(0));
        chk("zero_dv", 256'(dv_seen), 256'(0));
        chk("zero_dones", 256'(dones_seen), 256'(1));

        clear_counts();
        pulse_start(3);
        n = 0;
        while (reads_seen < 5 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("pre_reset_reads", 256'(reads_seen >= 5), 256'(1));
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        pend.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        @(negedge clk);
        stale_inj = 1'b1;
        @(negedge clk);
        stale_inj = 1'b0;
        repeat (3) @(negedge clk);
        chk("stale_dv", 256'(dv_seen), 256'(0));
        pulse_start(3);
        wait_done(3000);
        chk("rerun_reads", 256'(reads_seen), 256'(24));
        chk("rerun_beats", 256'(beats_seen), 256'(12));
        chk("rerun_dones", 256'(dones_seen), 256'(1));

        clear_counts();
        pulse_start(2);
        repeat (3) @(negedge clk);
        pulse_start(5);
        wait_done(3000);
        chk("restart_reads", 256'(reads_seen), 256'(16));
        chk("restart_beats", 256'(beats_seen), 256'(8));
        repeat (10) @(negedge clk);
        chk("restart_dones", 256'(dones_seen), 256'(1));
        chk("restart_busy", 256'(busy), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/res_drain.md
RES_DRAIN -- requirements
Module: res_drain

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: start  input  1  single-cycle pulse; begins a drain when IDLE.
REQ-004 SHALL have ports: tran_time  input  13  addresses per result bank; sampled on accepted start.
REQ-005 SHALL have ports: busy  output  1  high from accepted start until done.
REQ-006 SHALL have ports: done  output  1  one-cycle pulse when the last output beat is accepted.
REQ-007 SHALL have ports: bce  output  1  read strobe to the result bank selected by bsel.
REQ-008 SHALL have ports: bsel  output  3  result bank index, 0..7 mapping to banks 8..15.
REQ-009 SHALL have ports: braddr  output  15  bank read address.
REQ-010 SHALL have ports: brdata  input  128  bank read data.
REQ-011 SHALL have ports: brvalid  input  1  brdata is valid, in issue order, latency >= 1 cycle.
REQ-012 SHALL have ports: dout  output  256  packed result beat.
REQ-013 SHALL have ports: dout_valid  output  1  dout holds a beat.
REQ-014 SHALL have ports: dout_ready  input  1  consumer accepts the beat when dout_valid & dout_ready.

Function
REQ-015 SHALL implement the states IDLE, RUN, FLUSH and DONE.
REQ-016 SHALL leave IDLE only on start; start is ignored in every other state.
REQ-017 SHALL, on start with tran_time=0, enter DONE, pulse done next cycle and issue no reads.
REQ-018 SHALL issue reads in RUN, bank index inner and address outer: (a0,b0), (a0,b1) ... (a0,b7), (a1,b0) ... up to address tran_time-1.
REQ-019 SHALL issue 8*tran_time reads in total.
REQ-020 SHALL keep a 4-entry, 128-bit return FIFO.
REQ-021 SHALL issue a read (bce=1) only when FIFO occupancy plus outstanding reads < 4, so no returned word is ever dropped.
REQ-022 SHALL go from RUN to FLUSH in the cycle after the last read issues.
REQ-023 SHALL push every brvalid word into the FIFO.
REQ-024 SHALL pack two consecutive FIFO words per output beat: first word to dout[127:0], second to dout[255:128].
REQ-025 SHALL hold dout and dout_valid stable while dout_valid & !dout_ready.
REQ-026 SHALL allow the pack register to reload in the same cycle the current beat is accepted, giving full throughput of one beat per 2 reads.
REQ-027 SHALL go from FLUSH to DONE when the final beat is accepted, and drive done high for that one DONE cycle.
REQ-028 SHALL go from DONE to IDLE on the next cycle.
REQ-029 SHALL handle FIFO full and push simultaneously with pop as a legal pass-through, with no overflow.
REQ-030 SHALL treat brvalid with no outstanding read as a protocol error and ignore it.
REQ-031 SHALL, for the address counter at tran_time-1 with bank 7, terminate the drain with no wrap to address 0.

Reset
REQ-032 SHALL, on rst_n low, immediately set state IDLE and clear all counters and the FIFO.
REQ-033 SHALL, on rst_n low, drive these outputs to 0: busy, done, bce, bsel, braddr, dout, dout_valid.
REQ-034 SHALL, on reset mid-drain, abandon all outstanding reads; later brvalid returns are ignored per REQ-030.

Verification
REQ-035 SHALL cover: tran_time=1, dout_ready=1, bank k word = {16{8'h8k}} -> 4 beats, beat0 = {bank1,bank0} ... beat3 = {bank7,bank6}, done once, busy low afterwards.
REQ-036 SHALL cover: tran_time=2, 1-cycle read latency, dout_ready=1 -> 16 reads in order (a0 b0..b7, a1 b0..b7), 8 beats, steady state one beat per 2 cycles.
REQ-037 SHALL cover: tran_time=4, dout_ready held 0 for 20 cycles -> bce stops after 4 outstanding+buffered words, dout stable, no data lost, all 16 beats correct after release.
REQ-038 SHALL cover: start with tran_time=0 -> no bce, done pulses one cycle after start, no dout_valid.
REQ-039 SHALL cover: rst_n asserted after 5 reads of tran_time=3 -> all outputs 0 immediately; a new start then drains all 24 words correctly, with stale brvalid ignored.
REQ-040 SHALL cover: start pulsed again during RUN -> ignored, read count unchanged, exactly one done.
